// File: rtl/approx_div_pkg.sv
// Shared definitions for the approximate sequential divider.
//
// Contents:
//   div_state_e        controller state encoding (IDLE, BUSY, DONE)
//   DEF_WIDTH          default operand/quotient/remainder width
//   DEF_APPROX_ITERS   default quotient bits produced in approximate mode
//   DEF_CNT_W          iteration counter width for the default width
//   cnt_width()        counter width able to hold the value w (0..w)
package approx_div_pkg;

    localparam int DEF_WIDTH        = 32;
    localparam int DEF_APPROX_ITERS = 16;
    localparam int DEF_CNT_W        = $clog2(DEF_WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_e;

    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/div_restore_step.sv
// One restoring-division step (purely combinational).
//
// Ports:
//   r_in     partial remainder before the step (WIDTH+1 bits)
//   bit_in   next dividend bit, MSB first
//   divisor  divisor b
//   r_out    partial remainder after shift-in and optional subtract
//   q_bit    quotient bit produced by this step
module div_restore_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   r_in,
    input  logic             bit_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   r_out,
    output logic             q_bit
);

    logic [WIDTH:0] r_shift;
    logic           ge;

    // r_in is always < divisor, so its top bit is zero in practice; it is
    // still folded into the compare so the step stays correct on its own.
    assign r_shift = {r_in[WIDTH-1:0], bit_in};
    assign ge      = r_in[WIDTH] | (r_shift >= {1'b0, divisor});
    assign q_bit   = ge;
    assign r_out   = ge ? (r_shift - {1'b0, divisor}) : r_shift;

endmodule

// File: rtl/approx_seq_div32.sv
// Iterative restoring divider, unsigned a / b, with selectable accuracy.
// Precise mode produces all WIDTH quotient bits; approximate mode produces
// only the leading APPROX_ITERS bits and returns r = a - q*b exactly.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   in_valid/in_ready   request handshake (in_ready only in IDLE)
//   dividend, divisor   operands, sampled on the accepting edge
//   precise_en          1 = precise, 0 = approximate, sampled on accept
//   out_valid/out_ready result handshake
//   quotient, remainder result, held until the next result is loaded
//   div_by_zero         result came from a zero divisor
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for a request, in_ready = 1
// BUSY  | one restoring step per cycle, counter counts N down to 1
// DONE  | result presented (divide-by-zero loads it on its first cycle)
module approx_seq_div32
    import approx_div_pkg::*;
#(
    parameter int WIDTH        = DEF_WIDTH,
    parameter int APPROX_ITERS = DEF_APPROX_ITERS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             precise_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CNT_W = cnt_width(WIDTH);

    div_state_e state, state_next;

    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] n_iter;
    logic [CNT_W-1:0] k_skip;
    logic [WIDTH:0]   part_rem;
    logic [WIDTH-1:0] a_shift;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] q_shift;
    logic             out_valid_r;

    logic             accept;
    logic             last_step;
    logic [WIDTH:0]   r_next;
    logic             q_bit;
    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] a_next;
    logic [WIDTH-1:0] q_final;
    logic [WIDTH-1:0] r_final;

    assign in_ready  = (state == IDLE);
    assign out_valid = out_valid_r;
    assign accept    = in_valid && in_ready;
    assign last_step = (state == BUSY) && (count == CNT_W'(1));

    div_restore_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .r_in    (part_rem),
        .bit_in  (a_shift[WIDTH-1]),
        .divisor (b_reg),
        .r_out   (r_next),
        .q_bit   (q_bit)
    );

    assign a_next = a_shift << 1;
    assign q_next = (q_shift << 1) | WIDTH'(q_bit);

    // Bits never computed in approximate mode sit below the N produced
    // ones, so the quotient is left-aligned by K = WIDTH - N.
    assign k_skip  = CNT_W'(WIDTH) - n_iter;
    assign q_final = q_next << k_skip;

    // After N shifts the unconsumed dividend bits occupy the top K bits of
    // a_shift; shifting {R, a_shift} right by N yields {R, low K bits} =
    // a - q*b, which never exceeds a and so fits in WIDTH bits.
    assign r_final = WIDTH'({r_next, a_next} >> n_iter);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_next = (divisor == '0) ? DONE : BUSY;
                end
            end
            BUSY: begin
                if (last_step) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_valid_r && out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count       <= '0;
            n_iter      <= '0;
            part_rem    <= '0;
            a_shift     <= '0;
            b_reg       <= '0;
            q_shift     <= '0;
            out_valid_r <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        a_shift  <= dividend;
                        b_reg    <= divisor;
                        part_rem <= '0;
                        q_shift  <= '0;
                        n_iter   <= precise_en ? CNT_W'(WIDTH) : CNT_W'(APPROX_ITERS);
                        count    <= precise_en ? CNT_W'(WIDTH) : CNT_W'(APPROX_ITERS);
                    end
                end
                BUSY: begin
                    part_rem <= r_next;
                    a_shift  <= a_next;
                    q_shift  <= q_next;
                    count    <= count - CNT_W'(1);
                    if (last_step) begin
                        quotient    <= q_final;
                        remainder   <= r_final;
                        div_by_zero <= 1'b0;
                        out_valid_r <= 1'b1;
                    end
                end
                DONE: begin
                    // Only the zero-divisor path enters DONE with no result
                    // yet; it is loaded here, one cycle after acceptance.
                    if (!out_valid_r) begin
                        quotient    <= '1;
                        remainder   <= a_shift;
                        div_by_zero <= 1'b1;
                        out_valid_r <= 1'b1;
                    end else if (out_ready) begin
                        out_valid_r <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_approx_seq_div32.sv
module tb_approx_seq_div32;

    localparam int W  = 32;
    localparam int AI = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  dividend;
    logic [W-1:0]  divisor;
    logic          precise_en;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  quotient;
    logic [W-1:0]  remainder;
    logic          div_by_zero;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    approx_seq_div32 #(.WIDTH(W), .APPROX_ITERS(AI)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .precise_en  (precise_en),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    // Reference: plain integer division, then drop the low quotient bits
    // that approximate mode never computes; remainder is whatever is left.
    function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                    input logic p, output logic [W-1:0] q,
                                    output logic [W-1:0] r, output logic z,
                                    output int lat);
        longint unsigned qq;
        if (b == 0) begin
            q = '1; r = a; z = 1'b1; lat = 1;
        end else begin
            qq = longint'(a) / longint'(b);
            if (!p) qq = (qq >> (W - AI)) << (W - AI);
            q   = qq[W-1:0];
            r   = a - q * b;
            z   = 1'b0;
            lat = p ? W : AI;
        end
    endfunction

    // Drives one request from IDLE, scrambles the inputs after acceptance,
    // and returns the observed result and the edge count until out_valid.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic p,
                          output logic [W-1:0] q, output logic [W-1:0] r,
                          output logic z, output int lat);
        in_valid = 1'b1; dividend = a; divisor = b; precise_en = p;
        @(posedge clk); #1;
        in_valid = 1'b0; dividend = $urandom; divisor = $urandom; precise_en = 1'($urandom);
        lat = -1;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk); #1;
            if (out_valid) begin
                lat = i;
                break;
            end
        end
        q = quotient; r = remainder; z = div_by_zero;
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic check_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic p);
        logic [W-1:0] q, r, eq, er;
        logic         z, ez;
        int           lat, elat;
        ref_div(a, b, p, eq, er, ez, elat);
        run_op(a, b, p, q, r, z, lat);
        checks++; if (lat !== elat) begin errors++; $display("FAIL %s latency got %0d exp %0d", name, lat, elat); end
        checks++; if (q !== eq) begin errors++; $display("FAIL %s quotient a=%h b=%h p=%0d got %h exp %h", name, a, b, p, q, eq); end
        checks++; if (r !== er) begin errors++; $display("FAIL %s remainder a=%h b=%h p=%0d got %h exp %h", name, a, b, p, r, er); end
        checks++; if (z !== ez) begin errors++; $display("FAIL %s div_by_zero got %0d exp %0d", name, z, ez); end
        consume();
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL %s handshake out_valid=%0d in_ready=%0d exp 0/1", name, out_valid, in_ready); end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        dividend = '0; divisor = '0; precise_en = 1'b1;
        #12;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset in_ready got %0d exp 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset out_valid got %0d exp 0", out_valid); end
        checks++; if (quotient !== '0) begin errors++; $display("FAIL reset quotient got %h exp 0", quotient); end
        checks++; if (remainder !== '0) begin errors++; $display("FAIL reset remainder got %h exp 0", remainder); end
        checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL reset div_by_zero got %0d exp 0", div_by_zero); end
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        check_op("precise_100_7", 32'd100, 32'd7, 1'b1);
        check_op("approx_ffffffff_3", 32'hFFFF_FFFF, 32'd3, 1'b0);
        check_op("approx_100_7", 32'd100, 32'd7, 1'b0);
        check_op("dbz_precise", 32'h1234_5678, 32'd0, 1'b1);
        check_op("dbz_approx", 32'h1234_5678, 32'd0, 1'b0);
        check_op("a_zero", 32'd0, 32'd5, 1'b1);
        check_op("a_lt_b", 32'd17, 32'd99, 1'b1);
        check_op("b_one", 32'hCAFE_F00D, 32'd1, 1'b1);
        check_op("b_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    endtask

    task automatic test_backpressure();
        int lat;
        in_valid = 1'b1; dividend = 32'd1000; divisor = 32'd10; precise_en = 1'b1;
        @(posedge clk); #1;
        lat = -1;
        for (int i = 1; i <= 100; i++) begin
            // A competing request with a zero divisor is held through BUSY.
            in_valid = (i < 30); dividend = 32'd5; divisor = 32'd0; precise_en = 1'b0;
            @(posedge clk); #1;
            if (out_valid) begin lat = i; break; end
            if (i == 10) begin
                checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp busy in_ready got %0d exp 0", in_ready); end
            end
        end
        in_valid = 1'b0;
        checks++; if (lat !== W) begin errors++; $display("FAIL bp latency got %0d exp %0d", lat, W); end
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || quotient !== 32'd100 ||
                remainder !== 32'd0 || div_by_zero !== 1'b0) begin
                errors++;
                $display("FAIL bp hold cycle %0d ov=%0d ir=%0d q=%0d r=%0d z=%0d exp 1/0/100/0/0",
                         c, out_valid, in_ready, quotient, remainder, div_by_zero);
            end
            @(posedge clk); #1;
        end
        consume();
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL bp after in_ready=%0d out_valid=%0d exp 1/0", in_ready, out_valid); end
        checks++; if (quotient !== 32'd100 || remainder !== 32'd0) begin errors++; $display("FAIL bp retained q=%0d r=%0d exp 100/0", quotient, remainder); end
    endtask

    task automatic test_early_ready();
        logic [W-1:0] q, r;
        logic         z;
        int           lat;
        out_ready = 1'b1;
        run_op(32'd5000, 32'd7, 1'b1, q, r, z, lat);
        checks++; if (lat !== W) begin errors++; $display("FAIL early_ready latency got %0d exp %0d", lat, W); end
        checks++; if (q !== 32'd714 || r !== 32'd2) begin errors++; $display("FAIL early_ready result q=%0d r=%0d exp 714/2", q, r); end
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL early_ready drop out_valid=%0d in_ready=%0d exp 0/1", out_valid, in_ready); end
    endtask

    task automatic test_reset_mid_op();
        logic seen;
        in_valid = 1'b1; dividend = 32'hDEAD_BEEF; divisor = 32'h1234; precise_en = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid ready/valid got %0d/%0d exp 1/0", in_ready, out_valid); end
        checks++; if (quotient !== '0 || remainder !== '0 || div_by_zero !== 1'b0) begin errors++; $display("FAIL rst_mid outputs q=%h r=%h z=%0d exp 0", quotient, remainder, div_by_zero); end
        @(negedge clk); rst = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rst_mid abandoned result appeared got 1 exp 0"); end
        check_op("after_rst_81_9", 32'd81, 32'd9, 1'b1);
    endtask

    task automatic test_random();
        logic [W-1:0] a, b;
        logic         p;
        for (int n = 0; n < 40; n++) begin
            a = $urandom;
            p = 1'($urandom);
            case ($urandom_range(0, 5))
                0: b = '0;
                1: b = 32'd1;
                2: begin b = $urandom | 32'h8000_0000; a = b - 32'($urandom_range(1, 1000)); end
                3: begin a = '0; b = $urandom | 32'd1; end
                4: b = 32'($urandom_range(2, 300));
                default: b = $urandom >> $urandom_range(0, 31);
            endcase
            check_op("random", a, b, p);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_early_ready();
        test_reset_mid_op();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
